// File: rtl/aes_ctrl_pkg.sv
// Shared types and defaults for the AES job scheduler: FSM state encoding,
// default key/block width and WAIT timeout.
package aes_ctrl_pkg;

    localparam int KEY_W_DEF   = 128;
    localparam int TIMEOUT_DEF = 64;
    // Wide enough for the largest legal TIMEOUT (255).
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Requester index to one-hot requester mask.
    function automatic logic [1:0] idx_to_mask(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational one-hot grant, with a priority
// pointer that moves only when the grant is actually taken.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie.
    logic rr_ptr;

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= grant[0];
        end
    end

endmodule

// File: rtl/aes_scheduler.sv
// Schedules jobs from two requesters onto a single AES encrypt core, with
// round-robin arbitration, a WAIT timeout and held responses under backpressure.
module aes_scheduler
    import aes_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int KEY_W   = KEY_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*KEY_W-1:0] req_pt,
    input  logic [2*KEY_W-1:0] req_key,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [KEY_W-1:0]   rsp_ct,
    output logic               rsp_err,
    output logic               core_load,
    output logic [KEY_W-1:0]   core_pt,
    output logic [KEY_W-1:0]   core_key,
    input  logic [KEY_W-1:0]   core_ct,
    input  logic               core_valid
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [1:0]         grant;
    logic               accept;
    logic               gnt_idx;
    logic [KEY_W-1:0]   job_pt, job_key;
    logic [KEY_W-1:0]   sel_pt, sel_key;
    logic [CNT_W-1:0]   wait_cnt;
    logic               timeout_hit;
    logic               rsp_done;

    rr_arbiter_2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    assign accept      = (state == ST_IDLE) && |(req_valid & grant);
    assign sel_pt      = grant[1] ? req_pt[2*KEY_W-1:KEY_W]  : req_pt[KEY_W-1:0];
    assign sel_key     = grant[1] ? req_key[2*KEY_W-1:KEY_W] : req_key[KEY_W-1:0];
    assign timeout_hit = (wait_cnt == LAST_CNT);
    assign rsp_done    = rsp_ready[gnt_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_WAIT;
            ST_WAIT: if (core_valid || timeout_hit) state_nxt = ST_RESP;
            ST_RESP: if (rsp_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        core_load = 1'b0;
        core_pt   = '0;
        core_key  = '0;
        if (state == ST_IDLE) begin
            req_ready = grant;
        end else begin
            core_pt  = job_pt;
            core_key = job_key;
        end
        if (state == ST_LOAD) core_load = 1'b1;
        if (state == ST_RESP) rsp_valid = idx_to_mask(gnt_idx);
    end

    // Job capture on accept; result capture (core or timeout) in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_idx  <= 1'b0;
            job_pt   <= '0;
            job_key  <= '0;
            wait_cnt <= '0;
            rsp_ct   <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                gnt_idx <= grant[1];
                job_pt  <= sel_pt;
                job_key <= sel_key;
            end
            if (state == ST_WAIT) begin
                if (core_valid) begin
                    rsp_ct   <= core_ct;
                    rsp_err  <= 1'b0;
                    wait_cnt <= '0;
                end else if (timeout_hit) begin
                    rsp_ct   <= '0;
                    rsp_err  <= 1'b1;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/aes_scheduler.md
AES_SCHEDULER -- requirements
Module: aes_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum WAIT cycles before aborting a job (range 2..255).
REQ-002 Parameter KEY_W, default 128: key and block width in bits.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  2  per-requester job request.
REQ-007 req_ready  out  2  per-requester job accept strobe.
REQ-008 req_pt  in  2*KEY_W  plaintexts; requester i occupies bits [i*KEY_W +: KEY_W].
REQ-009 req_key  in  2*KEY_W  keys, same packing as req_pt.
REQ-010 rsp_valid  out  2  per-requester result available.
REQ-011 rsp_ready  in  2  per-requester result consumed.
REQ-012 rsp_ct  out  KEY_W  result ciphertext, shared between requesters.
REQ-013 rsp_err  out  1  result invalid because of timeout.
REQ-014 core_load  out  1  start pulse to the AES encrypt core.
REQ-015 core_pt  out  KEY_W  plaintext to the core.
REQ-016 core_key  out  KEY_W  key to the core.
REQ-017 core_ct  in  KEY_W  core ciphertext.
REQ-018 core_valid  in  1  core ciphertext valid.

Function
REQ-019 FSM states: IDLE, LOAD, WAIT, RESP; reset state IDLE.
REQ-020 Arbitration: in IDLE, req_ready SHALL be one-hot combinational to the granted requester, or 0 if no req_valid.
REQ-021 Round-robin: when both req_valid are high, grant goes to the requester not granted last; a sole requester is always granted.
REQ-022 Accept on req_valid[g] & req_ready[g]: register g, req_pt[g] and req_key[g]; next state LOAD.
REQ-023 LOAD lasts exactly 1 cycle with core_load=1; next state WAIT.
REQ-024 core_pt and core_key SHALL hold the accepted job from LOAD until the job leaves RESP; they are 0 otherwise.
REQ-025 WAIT: the first cycle with core_valid=1 captures core_ct into rsp_ct, sets rsp_err=0, and moves to RESP.
REQ-026 WAIT timeout: a cycle counter starts at 0 on entry to WAIT. If it reaches TIMEOUT with no core_valid, set rsp_ct=0 and rsp_err=1, and move to RESP.
REQ-027 core_valid outside WAIT SHALL be ignored.
REQ-028 RESP: rsp_valid[g]=1 only; rsp_ct and rsp_err are held stable until rsp_valid[g] & rsp_ready[g]. Then go to IDLE.
REQ-029 rsp_ready[g] may be high on RESP entry; the result then completes in 1 cycle. rsp_ready of the non-granted requester is ignored.
REQ-030 No new request is accepted in the cycle RESP completes; minimum job interval = 1 (IDLE) + 1 (LOAD) + core latency + 1 (RESP).
REQ-031 Outside RESP, rsp_valid=0. Outside IDLE, req_ready=0.
REQ-032 The round-robin pointer updates only on accept, never on timeout or response.

Reset
REQ-033 On rst: FSM to IDLE; round-robin pointer favours requester 0; req_ready=0, rsp_valid=0, rsp_ct=0, rsp_err=0, core_load=0, core_pt=0, core_key=0, counter=0.
REQ-034 rst mid-job SHALL abandon the job with no response, and subsequent core_valid SHALL be ignored.

Structure
REQ-035 Shared package aes_ctrl_pkg SHALL hold the FSM state enum, KEY_W default and TIMEOUT default.
REQ-036 One sub-module, rr_arbiter_2, SHALL implement the 2-way round-robin grant and pointer; all other logic stays in aes_scheduler.

Verification
REQ-037 Single job: requester 0 sends key 000102030405060708090a0b0c0d0e0f and pt 00112233445566778899aabbccddeeff. A core model with 10-cycle latency is used. Required: exactly one core_load pulse, rsp_valid[0], rsp_ct=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
REQ-038 Contention: both req_valid held high for 4 jobs. Required: grants in order 0,1,0,1, each rsp_valid on the matching index.
REQ-039 Timeout: core model never asserts valid, TIMEOUT=64. Required: rsp_valid 64 cycles after WAIT entry, rsp_err=1, rsp_ct=0.
REQ-040 Backpressure: rsp_ready held low for 20 cycles. Required: rsp_ct stable, req_ready=0 throughout, then completion on rsp_ready.
REQ-041 Reset mid-WAIT: assert rst 5 cycles after core_load. Required: all outputs 0 immediately, no response, and a late core_valid ignored.
REQ-042 Spurious valid: core_valid pulsed in IDLE. Required: no state change and rsp_valid stays 0.
